// File: rtl/mat_pkg.sv
// Shared types and width helpers for the streaming matrix multiplier.
// Also holds the result narrowing (shift then clamp or truncate).
package mat_pkg;

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    EMIT
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int acc_w(input int n, input int dw);
    return 2 * dw + max1(clog2(n));
  endfunction

  function automatic int idx_w(input int n);
    return max1(clog2(n));
  endfunction

  function automatic int addr_w(input int n);
    return max1(clog2(n * n));
  endfunction

  function automatic int cnt_w(input int n);
    return clog2(n * n + 1);
  endfunction

  function automatic logic [63:0] narrow(
    input logic [63:0] acc,
    input int          shift,
    input int          out_w,
    input bit          sat
  );
    logic [63:0] s;
    logic [63:0] m;
    s = acc >> shift;
    m = (64'd1 << out_w) - 64'd1;
    if (sat && (s > m)) return m;
    return s & m;
  endfunction

endpackage

// File: rtl/mat_operand_buf.sv
// One N*N operand store: row-major write counter, registered accept,
// full flag and an unregistered indexed read port.
module mat_operand_buf
  import mat_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DATA_W-1:0]         i_num,
  input  logic                      i_num_valid,
  input  logic                      i_load,
  input  logic                      i_clr,
  output logic                      o_read,
  output logic                      o_full,
  input  logic [addr_w(N)-1:0]      i_rd_idx,
  output logic [DATA_W-1:0]         o_rd_data
);

  localparam int NN = N * N;
  localparam int AW = addr_w(N);
  localparam int CW = cnt_w(N);

  logic [DATA_W-1:0] mem [NN];
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              wr;

  assign wr = o_read & i_num_valid;

  always_comb begin
    cnt_nxt = cnt;
    if (i_clr) cnt_nxt = '0;
    else if (wr) cnt_nxt = cnt + CW'(1);
  end

  // accept drops on the edge that takes the last element
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      o_read <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      o_read <= i_load && (cnt_nxt < CW'(NN));
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr) mem[cnt[AW-1:0]] <= i_num;
  end

  assign o_full    = (cnt == CW'(NN));
  assign o_rd_data = mem[i_rd_idx];

endmodule

// File: rtl/mat_mult_stream.sv
// Streaming N x N unsigned matrix multiplier: buffer A and B,
// one MAC per cycle, emit C row-major over valid/ready.
module mat_mult_stream
  import mat_pkg::*;
#(
  parameter int N         = 3,
  parameter int DATA_W    = 8,
  parameter int OUT_W     = 8,
  parameter int RES_SHIFT = 0,
  parameter int SATURATE  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_a_num,
  input  logic              i_a_num_valid,
  output logic              o_a_read,
  input  logic [DATA_W-1:0] i_b_num,
  input  logic              i_b_num_valid,
  output logic              o_b_read,
  input  logic              i_res_ready,
  output logic [OUT_W-1:0]  o_res_data,
  output logic              o_res_valid,
  output logic              o_res_last
);

  localparam int ACC_W = acc_w(N, DATA_W);
  localparam int IW    = idx_w(N);
  localparam int AW    = addr_w(N);
  localparam logic [IW-1:0] NM1 = IW'(N - 1);

  state_t state, state_nxt;

  logic              a_full, b_full;
  logic              armed, go, fire;
  logic              k_end, last_el;
  logic              load_en;
  logic [IW-1:0]     row, col, k;
  logic [AW-1:0]     a_addr, b_addr;
  logic [DATA_W-1:0] a_val, b_val;
  logic [ACC_W-1:0]  acc, acc_sum;

  mat_operand_buf #(.N(N), .DATA_W(DATA_W)) u_a (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_num      (i_a_num),
    .i_num_valid(i_a_num_valid),
    .i_load     (load_en),
    .i_clr      (go),
    .o_read     (o_a_read),
    .o_full     (a_full),
    .i_rd_idx   (a_addr),
    .o_rd_data  (a_val)
  );

  mat_operand_buf #(.N(N), .DATA_W(DATA_W)) u_b (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_num      (i_b_num),
    .i_num_valid(i_b_num_valid),
    .i_load     (load_en),
    .i_clr      (go),
    .o_read     (o_b_read),
    .o_full     (b_full),
    .i_rd_idx   (b_addr),
    .o_rd_data  (b_val)
  );

  assign k_end   = (k == NM1);
  assign last_el = (row == NM1) && (col == NM1);
  assign fire    = o_res_valid && i_res_ready;
  assign go      = (state == LOAD) && armed;
  assign a_addr  = AW'(row) * AW'(N) + AW'(k);
  assign b_addr  = AW'(k) * AW'(N) + AW'(col);
  assign acc_sum = ((k == '0) ? '0 : acc)
                 + ACC_W'(a_val) * ACC_W'(b_val);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: if (go) state_nxt = CALC;
      CALC: if (k_end) state_nxt = EMIT;
      EMIT: if (fire) state_nxt = o_res_last ? LOAD : CALC;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    load_en = (state_nxt == LOAD);
  end

  // armed adds the single settle cycle between both-full and CALC
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) armed <= 1'b0;
    else armed <= (state == LOAD) && a_full && b_full && !armed;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row         <= '0;
      col         <= '0;
      k           <= '0;
      acc         <= '0;
      o_res_data  <= '0;
      o_res_valid <= 1'b0;
      o_res_last  <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (go) begin
            row <= '0;
            col <= '0;
            k   <= '0;
          end
        end
        CALC: begin
          acc <= acc_sum;
          if (k_end) begin
            k           <= '0;
            o_res_data  <= OUT_W'(narrow(64'(acc_sum), RES_SHIFT,
                                         OUT_W, SATURATE != 0));
            o_res_valid <= 1'b1;
            o_res_last  <= last_el;
          end else begin
            k <= k + IW'(1);
          end
        end
        EMIT: begin
          if (fire) begin
            o_res_valid <= 1'b0;
            o_res_last  <= 1'b0;
            if (o_res_last) begin
              row <= '0;
              col <= '0;
            end else if (col == NM1) begin
              col <= '0;
              row <= row + IW'(1);
            end else begin
              col <= col + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_stream.sv
// Scoreboard bench: three parameter variants share one stimulus stream;
// expected C values come from a plain triple-loop reference.
module tb_mat_mult_stream;

  localparam int N  = 3;
  localparam int NN = N * N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_num, b_num;
  logic       a_valid, b_valid, rdy;
  logic       a_read [3];
  logic       b_read [3];
  logic       res_valid [3];
  logic       res_last [3];
  logic [7:0] res_data [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode;
  int first_vld;
  int b_done;
  int reread_at;

  typedef struct packed {
    logic       last;
    logic [7:0] v2;
    logic [7:0] v1;
    logic [7:0] v0;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mat_mult_stream #(.N(N), .DATA_W(8), .OUT_W(8),
                    .RES_SHIFT(0), .SATURATE(1)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_num(a_num), .i_a_num_valid(a_valid), .o_a_read(a_read[0]),
    .i_b_num(b_num), .i_b_num_valid(b_valid), .o_b_read(b_read[0]),
    .i_res_ready(rdy), .o_res_data(res_data[0]),
    .o_res_valid(res_valid[0]), .o_res_last(res_last[0])
  );

  mat_mult_stream #(.N(N), .DATA_W(8), .OUT_W(8),
                    .RES_SHIFT(8), .SATURATE(1)) u_shf (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_num(a_num), .i_a_num_valid(a_valid), .o_a_read(a_read[1]),
    .i_b_num(b_num), .i_b_num_valid(b_valid), .o_b_read(b_read[1]),
    .i_res_ready(rdy), .o_res_data(res_data[1]),
    .o_res_valid(res_valid[1]), .o_res_last(res_last[1])
  );

  mat_mult_stream #(.N(N), .DATA_W(8), .OUT_W(8),
                    .RES_SHIFT(0), .SATURATE(0)) u_trn (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_num(a_num), .i_a_num_valid(a_valid), .o_a_read(a_read[2]),
    .i_b_num(b_num), .i_b_num_valid(b_valid), .o_b_read(b_read[2]),
    .i_res_ready(rdy), .o_res_data(res_data[2]),
    .o_res_valid(res_valid[2]), .o_res_last(res_last[2])
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fit(input longint c, input int sh,
                                     input bit sat);
    longint s;
    s = c >> sh;
    if (sat && s > 255) return 8'hFF;
    return s[7:0];
  endfunction

  task automatic expect_mat(input int a[$], input int b[$]);
    exp_t e;
    longint c;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        c = 0;
        for (int k = 0; k < N; k++)
          c += longint'(a[i*N+k]) * longint'(b[k*N+j]);
        e.last = (i == N-1) && (j == N-1);
        e.v0 = fit(c, 0, 1'b1);
        e.v1 = fit(c, 8, 1'b1);
        e.v2 = fit(c, 0, 1'b0);
        sb.push_back(e);
      end
    end
  endtask

  task automatic rnd_mat(output int m[$]);
    m.delete();
    for (int i = 0; i < NN; i++) m.push_back($urandom_range(0, 255));
  endtask

  task automatic feed_a(input int vals[$], input bit gaps);
    int idx;
    int budget;
    bit fire;
    idx = 0;
    budget = 3000;
    while (idx < vals.size() && budget > 0) begin
      a_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      a_num = 8'(vals[idx]);
      @(negedge clk);
      fire = a_valid && a_read[0];
      @(posedge clk);
      #1;
      budget--;
      if (fire) begin
        idx++;
        if (idx % NN == 0) check("a_read_drop", a_read[0], 0);
      end
    end
    a_valid = 1'b0;
    check("a_feed_done", idx, vals.size());
  endtask

  task automatic feed_b(input int vals[$], input bit gaps);
    int idx;
    int budget;
    bit fire;
    idx = 0;
    budget = 3000;
    while (idx < vals.size() && budget > 0) begin
      b_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_num = 8'(vals[idx]);
      @(negedge clk);
      fire = b_valid && b_read[0];
      @(posedge clk);
      #1;
      budget--;
      if (fire) begin
        idx++;
        if (idx == vals.size()) b_done = cyc;
        if (idx % NN == 0) check("b_read_drop", b_read[0], 0);
      end
    end
    b_valid = 1'b0;
    check("b_feed_done", idx, vals.size());
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() > 0 && b < 3000) begin
      @(posedge clk);
      b++;
    end
    check("drain_left", sb.size(), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run(input int aq[$], input int bq[$], input bit gaps);
    fork
      feed_a(aq, gaps);
      feed_b(bq, gaps);
    join
    drain();
  endtask

  task automatic wait_val(input int v);
    int b;
    b = 0;
    while (!(res_valid[0] && res_data[0] == 8'(v)) && b < 500) begin
      @(posedge clk);
      #2;
      b++;
    end
    check("wait_val_seen", int'(res_valid[0] && res_data[0] == 8'(v)), 1);
  endtask

  task automatic stall_at(input int v);
    wait_val(v);
    rdy_mode = 2;
    rdy = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("stall_hold_data", res_data[0], v);
    check("stall_hold_valid", res_valid[0], 1);
    rdy = 1'b1;
    rdy_mode = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) rdy = 1'b1;
      else if (rdy_mode == 1) rdy = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (cyc == reread_at) begin
        check("reread_a", a_read[0], 1);
        check("reread_b", b_read[0], 1);
      end
      if (res_valid[0]) begin
        if (first_vld < 0) first_vld = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0d expected none",
                   res_data[0]);
        end else begin
          e = sb[0];
          check("c_sat", res_data[0], e.v0);
          check("c_shift8", res_data[1], e.v1);
          check("c_trunc", res_data[2], e.v2);
          check("c_last", res_last[0], e.last);
          check("c_valid_all", res_valid[1] && res_valid[2], 1);
          if (rdy) begin
            void'(sb.pop_front());
            if (e.last) reread_at = cyc + 1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    int ra[$];
    int id[$];
    int sq[$];
    int m1[$], m2[$], m3[$], m4[$];
    int mx[$];
    ra = '{16, 32, 48, 16, 32, 48, 16, 32, 48};
    id = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    sq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_num = '0;
    b_num = '0;
    rdy = 1'b1;
    rdy_mode = 0;
    first_vld = -1;
    reread_at = -1;
    b_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", res_valid[0], 0);
    check("rst_data", res_data[0], 0);
    check("rst_last", res_last[0], 0);
    check("rst_a_read", a_read[0], 0);
    check("rst_b_read", b_read[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("a_read_rise", a_read[0], 1);
    check("b_read_rise", b_read[0], 1);

    expect_mat(ra, ra);
    run(ra, ra, 1'b0);

    expect_mat(id, sq);
    fork
      run(id, sq, 1'b0);
      stall_at(4);
    join

    rnd_mat(m1);
    rnd_mat(m2);
    expect_mat(m1, m2);
    first_vld = -1;
    fork
      begin
        feed_a(m1, 1'b0);
        check("skew_b_waiting", b_read[0], 1);
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        feed_b(m2, 1'b0);
      end
    join
    drain();
    check("skew_latency", first_vld - b_done, N + 2);

    expect_mat(id, sq);
    fork
      feed_a(id, 1'b0);
      feed_b(sq, 1'b0);
      begin
        wait_val(5);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_valid", res_valid[0], 0);
        check("midrst_data", res_data[0], 0);
        check("midrst_last", res_last[0], 0);
        check("midrst_a_read", a_read[0], 0);
      end
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_mat(id, sq);
    run(id, sq, 1'b0);

    rnd_mat(m1);
    rnd_mat(m2);
    rnd_mat(m3);
    rnd_mat(m4);
    expect_mat(m1, m2);
    expect_mat(m3, m4);
    run({m1, m3}, {m2, m4}, 1'b0);

    rdy_mode = 1;
    for (int t = 0; t < 3; t++) begin
      rnd_mat(m1);
      rnd_mat(m2);
      expect_mat(m1, m2);
      run(m1, m2, 1'b1);
    end
    mx = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    expect_mat(mx, mx);
    run(mx, mx, 1'b1);
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
